ula_multiciclo: RTL and testbench

ULA_MULTICICLO -- requirements
Module: ula_multiciclo

---
 rtl/ula_multiciclo.sv | 201 ++++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// Multi-cycle unsigned ALU.
// A start request latches the op code and both operands.
// Single-cycle ops return their result on the next edge.
// Multiply (shift-add) and divide (restoring) take LARGURA iterations
// on the latched operands.
// Results, flags and the one-cycle concluido pulse are registered.
// Results hold until the next operation completes.
module ula_multiciclo #(
  parameter int LARGURA = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               processar,
  input  logic [3:0]         op,
  input  logic [LARGURA-1:0] ETp1,
  input  logic [LARGURA-1:0] ETp2,
  output logic [LARGURA-1:0] Data,
  output logic [LARGURA-1:0] Data_alto,
  output logic               concluido,
  output logic               ocupado,
  output logic [3:0]         flags
);

  localparam int CW = $clog2(LARGURA);

  localparam logic [3:0] OP_SOMA = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_E    = 4'd4;
  localparam logic [3:0] OP_NE   = 4'd5;
  localparam logic [3:0] OP_OU   = 4'd6;
  localparam logic [3:0] OP_XOU  = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;
  localparam logic [3:0] OP_NAO  = 4'd9;

  typedef enum logic [1:0] {
    ESPERA      = 2'd0,
    EXECUTANDO  = 2'd1,
    SAIDA_DADOS = 2'd2
  } estado_t;

  estado_t            estado_q;
  logic [3:0]         op_q;
  logic [LARGURA-1:0] a_q, b_q;
  // Iteration working pair.
  // Multiply: {partial product high, multiplier/product low}.
  // Divide: {partial remainder, dividend/quotient}.
  logic [LARGURA-1:0] hi_q, lo_q;
  logic [CW-1:0]      cnt_q;
  logic [LARGURA-1:0] data_q, data_alto_q;
  logic [3:0]         flags_q;
  logic               concluido_q, ocupado_q;

  logic [LARGURA:0]   soma_parcial;
  logic [LARGURA:0]   deslocado;
  logic [LARGURA-1:0] dif;
  logic               cabe;
  logic [LARGURA-1:0] passo_hi_d, passo_lo_d;
  logic               iterativo;
  logic               ultimo_passo;

  logic [LARGURA:0]   soma_ext;
  logic [LARGURA-1:0] res_d, alto_d;
  logic [3:0]         flags_d;
  logic               erro_d, div_zero_d, carry_d;

  // One multiply or divide iteration on the working pair.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path can leave it unassigned and infer a latch.
    passo_hi_d   = hi_q;
    passo_lo_d   = lo_q;
    // Shift-add: add B when the current multiplier bit is set, then shift the
    // whole {carry, hi, lo} right by one.
    soma_parcial = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Restoring division: shift the next dividend bit into the remainder.
    // Subtract B when it fits.
    // A zero divisor always "fits", so the quotient saturates to all ones.
    // The remainder then ends up holding A.
    deslocado    = {hi_q, lo_q[LARGURA-1]};
    cabe         = (deslocado >= {1'b0, b_q});
    dif          = deslocado[LARGURA-1:0] - b_q;
    if (op_q == OP_MUL) begin
      passo_hi_d = soma_parcial[LARGURA:1];
      passo_lo_d = {soma_parcial[0], lo_q[LARGURA-1:1]};
    end else begin
      passo_hi_d = cabe ? dif : deslocado[LARGURA-1:0];
      passo_lo_d = {lo_q[LARGURA-2:0], cabe};
    end
  end

  assign iterativo    = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign ultimo_passo = (cnt_q == CW'(LARGURA - 1));

  // Final result and flags for the latched op.
  // Iterative ops use the outcome of the current step.
  always_comb begin
    res_d      = '0;
    alto_d     = '0;
    erro_d     = 1'b0;
    div_zero_d = 1'b0;
    carry_d    = 1'b0;
    soma_ext   = {1'b0, a_q} + {1'b0, b_q};
    case (op_q)
      OP_SOMA: begin
        res_d   = soma_ext[LARGURA-1:0];
        carry_d = soma_ext[LARGURA];
      end
      OP_SUB: begin
        res_d   = a_q - b_q;
        carry_d = (a_q < b_q);
      end
      OP_MUL: begin
        res_d  = passo_lo_d;
        alto_d = passo_hi_d;
      end
      OP_DIV: begin
        res_d      = passo_lo_d;
        alto_d     = passo_hi_d;
        div_zero_d = (b_q == '0);
      end
      OP_E:    res_d = a_q & b_q;
      OP_NE:   res_d = ~(a_q & b_q);
      OP_OU:   res_d = a_q | b_q;
      OP_XOU:  res_d = a_q ^ b_q;
      OP_CMP:  res_d = {{(LARGURA-1){1'b0}}, (a_q == b_q)};
      OP_NAO:  res_d = ~a_q;
      default: erro_d = 1'b1;
    endcase
    flags_d = {erro_d, div_zero_d, carry_d, (res_d == '0)};
  end

  // Control FSM with registered outputs and operand/iteration registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (!reset) begin
      estado_q    <= ESPERA;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      data_alto_q <= '0;
      flags_q     <= '0;
      concluido_q <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      case (estado_q)
        ESPERA: begin
          concluido_q <= 1'b0;
          if (processar) begin
            op_q      <= op;
            a_q       <= ETp1;
            b_q       <= ETp2;
            hi_q      <= '0;
            lo_q      <= ETp1;
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
            estado_q  <= EXECUTANDO;
          end
        end
        EXECUTANDO: begin
          if (iterativo) begin
            hi_q  <= passo_hi_d;
            lo_q  <= passo_lo_d;
            cnt_q <= cnt_q + CW'(1);
          end
          if (!iterativo || ultimo_passo) begin
            data_q      <= res_d;
            data_alto_q <= alto_d;
            flags_q     <= flags_d;
            concluido_q <= 1'b1;
            cnt_q       <= '0;
            estado_q    <= SAIDA_DADOS;
          end
        end
        SAIDA_DADOS: begin
          concluido_q <= 1'b0;
          ocupado_q   <= 1'b0;
          estado_q    <= ESPERA;
        end
        default: begin
          concluido_q <= 1'b0;
          ocupado_q   <= 1'b0;
          estado_q    <= ESPERA;
        end
      endcase
    end
  end

  assign Data      = data_q;
  assign Data_alto = data_alto_q;
  assign flags     = flags_q;
  assign concluido = concluido_q;
  assign ocupado   = ocupado_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo (LARGURA = 16).
// Directed spec vectors and random ops are checked against an arithmetic
// reference model.
// The bench also covers mid-operation reset, ignored requests while busy,
// and back-to-back starts.
module tb_ula_multiciclo;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         processar;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] Data, Data_alto;
  logic         concluido, ocupado;
  logic [3:0]   flags;

  int errors = 0;
  int checks = 0;

  ula_multiciclo #(.LARGURA(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .processar (processar),
    .op        (op),
    .ETp1      (a),
    .ETp2      (b),
    .Data      (Data),
    .Data_alto (Data_alto),
    .concluido (concluido),
    .ocupado   (ocupado),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on wide integers.
  function automatic void modelo(input logic [3:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, output logic [W-1:0] d,
                                 output logic [W-1:0] h, output logic [3:0] f);
    longint unsigned ax, by, r;
    logic erro, dz, cy;
    ax = longint'(x);
    by = longint'(y);
    erro = 1'b0; dz = 1'b0; cy = 1'b0;
    d = '0; h = '0;
    case (o)
      4'd0: begin r = ax + by; d = W'(r); cy = ((r >> W) != 0); end
      4'd1: begin d = W'(ax - by); cy = (ax < by); end
      4'd2: begin r = ax * by; d = W'(r); h = W'(r >> W); end
      4'd3: begin
        if (by == 0) begin d = '1; h = x; dz = 1'b1; end
        else begin d = W'(ax / by); h = W'(ax % by); end
      end
      4'd4: d = x & y;
      4'd5: d = ~(x & y);
      4'd6: d = x | y;
      4'd7: d = x ^ y;
      4'd8: d = (x == y) ? W'(1) : W'(0);
      4'd9: d = ~x;
      default: erro = 1'b1;
    endcase
    f = {erro, dz, cy, (d == '0)};
  endfunction

  function automatic int lat_esperada(input logic [3:0] o);
    return (o == 4'd2 || o == 4'd3) ? W : 1;
  endfunction

  // Starts one op and waits (bounded) for concluido.
  // Returns the outputs seen during the pulse, the latency in edges after
  // the accepting edge (-1 on timeout), and whether ocupado stayed high.
  // It also reports whether the pulse was one cycle wide, with ocupado
  // dropping and the outputs held on the next cycle.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] d, output logic [W-1:0] h, output logic [3:0] f,
                        output int lat, output bit busy_ok, output bit pulse_ok);
    @(negedge clk);
    processar = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    processar = 1'b0;
    busy_ok = ocupado;
    lat = 0;
    while (lat < 200 && !concluido) begin
      @(posedge clk); #1;
      lat++;
      if (!ocupado) busy_ok = 1'b0;
    end
    if (!concluido) lat = -1;
    d = Data; h = Data_alto; f = flags;
    @(posedge clk); #1;
    pulse_ok = !concluido && !ocupado && (Data === d) && (Data_alto === h) && (flags === f);
  endtask

  task automatic test_reset();
    reset = 1'b0; processar = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({Data, Data_alto, flags, concluido, ocupado} !== '0) begin
      errors++;
      $display("FAIL reset_state: got Data=%h alto=%h flags=%b conc=%b ocup=%b, want all 0",
               Data, Data_alto, flags, concluido, ocupado);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0]   o;
    logic [W-1:0] x, y, d, h;
    logic [3:0]   f;
  } vec_t;

  task automatic test_directed();
    vec_t v[12];
    logic [W-1:0] d, h; logic [3:0] f; int lat; bit bok, pok;
    v[0]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0011};
    v[1]  = '{4'd1,  16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 4'b0010};
    v[2]  = '{4'd8,  16'h1234, 16'h1234, 16'h0001, 16'h0000, 4'b0000};
    v[3]  = '{4'd9,  16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 4'b0000};
    v[4]  = '{4'd12, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b1001};
    v[5]  = '{4'd2,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0000};
    v[6]  = '{4'd3,  16'd1000, 16'd7,    16'h008E, 16'h0006, 4'b0000};
    v[7]  = '{4'd3,  16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 4'b0100};
    v[8]  = '{4'd4,  16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 4'b0000};
    v[9]  = '{4'd5,  16'hF0F0, 16'hFF00, 16'h0FFF, 16'h0000, 4'b0000};
    v[10] = '{4'd6,  16'hF0F0, 16'hFF00, 16'hFFF0, 16'h0000, 4'b0000};
    v[11] = '{4'd7,  16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].o, v[i].x, v[i].y, d, h, f, lat, bok, pok);
      checks++;
      if (d !== v[i].d || h !== v[i].h || f !== v[i].f) begin
        errors++;
        $display("FAIL directed_result[%0d] op=%0d: got %h/%h/%b, want %h/%h/%b",
                 i, v[i].o, d, h, f, v[i].d, v[i].h, v[i].f);
      end
      checks++;
      if (lat !== lat_esperada(v[i].o) || !bok || !pok) begin
        errors++;
        $display("FAIL directed_timing[%0d] op=%0d: lat=%0d busy_ok=%0b pulse_ok=%0b, want lat=%0d 1 1",
                 i, v[i].o, lat, bok, pok, lat_esperada(v[i].o));
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d, h, ed, eh, x, y; logic [3:0] f, ef, o; int lat; bit bok, pok;
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15));
      x = W'($urandom);
      y = ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom >> $urandom_range(0, 15));
      modelo(o, x, y, ed, eh, ef);
      run_op(o, x, y, d, h, f, lat, bok, pok);
      checks++;
      if (d !== ed || h !== eh || f !== ef || lat !== lat_esperada(o) || !bok || !pok) begin
        errors++;
        $display("FAIL random[%0d] op=%0d A=%h B=%h: got %h/%h/%b lat=%0d b=%0b p=%0b, want %h/%h/%b lat=%0d",
                 i, o, x, y, d, h, f, lat, bok, pok, ed, eh, ef, lat_esperada(o));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] d, h; logic [3:0] f; int lat, pulsos; bit bok, pok;
    @(negedge clk);
    processar = 1'b1; op = 4'd2; a = 16'h1234; b = 16'h0100;
    @(posedge clk); #1;
    processar = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({Data, Data_alto, flags, concluido, ocupado} !== '0) begin
      errors++;
      $display("FAIL reset_async: got Data=%h alto=%h flags=%b conc=%b ocup=%b, want all 0",
               Data, Data_alto, flags, concluido, ocupado);
    end
    pulsos = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (concluido || ocupado) pulsos++;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (concluido || ocupado) pulsos++;
    end
    checks++;
    if (pulsos !== 0) begin
      errors++;
      $display("FAIL reset_abandon: got %0d busy/done cycles, want 0", pulsos);
    end
    run_op(4'd0, 16'd2, 16'd3, d, h, f, lat, bok, pok);
    checks++;
    if (d !== 16'd5 || f !== 4'b0000 || lat !== 1 || !pok) begin
      errors++;
      $display("FAIL reset_then_soma: got Data=%h flags=%b lat=%0d pulse_ok=%0b, want 0005 0000 1 1",
               d, f, lat, pok);
    end
  endtask

  task automatic test_ignore_busy();
    int lat, extra;
    @(negedge clk);
    processar = 1'b1; op = 4'd3; a = 16'd1000; b = 16'd7;
    @(posedge clk); #1;
    processar = 1'b0;
    lat = 0;
    while (lat < 200 && !concluido) begin
      @(negedge clk);
      processar = (lat == 2 || lat == 4);
      op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    processar = 1'b0;
    if (!concluido) lat = -1;
    checks++;
    if (Data !== 16'h008E || Data_alto !== 16'h0006 || flags !== 4'b0000 || lat !== W) begin
      errors++;
      $display("FAIL ignore_busy: got %h/%h/%b lat=%0d, want 008e/0006/0000 lat=%0d",
               Data, Data_alto, flags, lat, W);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (concluido || ocupado) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_no_start: got %0d busy cycles after completion, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ed, eh; logic [3:0] ef; int pulsos, guard;
    @(negedge clk);
    processar = 1'b1; op = 4'd0; a = W'($urandom); b = W'($urandom);
    @(posedge clk); #1;
    pulsos = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (concluido) begin
        modelo(4'd0, a, b, ed, eh, ef);
        checks++;
        if (e !== 1 + 3 * pulsos || Data !== ed || flags !== ef) begin
          errors++;
          $display("FAIL b2b_pulse[%0d]: edge=%0d Data=%h flags=%b, want edge=%0d %h/%b",
                   pulsos, e, Data, flags, 1 + 3 * pulsos, ed, ef);
        end
        pulsos++;
        a = W'($urandom); b = W'($urandom);
      end
    end
    processar = 1'b0;
    checks++;
    if (pulsos !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses, want 4", pulsos);
    end
    guard = 0;
    while (guard < 50 && (ocupado || concluido)) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (ocupado) begin
      errors++;
      $display("FAIL b2b_drain: still busy after %0d cycles, want idle", guard);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_op();
    test_ignore_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
